// File: rtl/hdr_line_pairer.sv
// Stores the long-exposure line and pairs it column by column with the short-exposure line that follows.
// Latency: 2 cycles from an accepted short pixel to valid_o (RAM read/flag stage, then output register).
// Backpressure: none. Input is accepted every valid_i cycle. Pixels that overrun the buffer or the stored line length are dropped and flagged on err_o.
module hdr_line_pairer #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_MAX   = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pix_i,
  input  logic                  valid_i,
  input  logic                  sof_i,
  input  logic                  eol_i,
  output logic [DATA_WIDTH-1:0] data_o0,
  output logic [DATA_WIDTH-1:0] data_o1,
  output logic                  valid_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  err_o
);

  // The counters need one extra bit so they can hold LINE_MAX itself.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LMAX = CNT_W'(LINE_MAX);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LONG, S_SHORT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic                   err_q, err_d;
  logic                   sof_pend_q, sof_pend_d;

  logic                   acc_sof;
  logic                   wr_en, rd_en, pair_en;
  logic [ADDR_W-1:0]      wr_addr, rd_addr;

  logic [DATA_WIDTH-1:0]  mem [LINE_MAX];
  logic [DATA_WIDTH-1:0]  rd_dat_q;
  logic [DATA_WIDTH-1:0]  s1_pix_q;
  logic                   s1_vld_q, s1_sof_q, s1_eol_q;

  // A qualified start of frame overrides everything else, in any state.
  assign acc_sof = valid_i & sof_i;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      sof_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      sof_pend_q <= sof_pend_d;
    end
  end

  // Next state: sof resyncs to LONG. eol alternates LONG <-> SHORT.
  always_comb begin
    state_d = state_q;
    if (acc_sof) begin
      // A one-pixel long line goes straight to its short line.
      state_d = eol_i ? S_SHORT : S_LONG;
    end else if (valid_i && eol_i) begin
      case (state_q)
        S_LONG:  state_d = S_SHORT;
        S_SHORT: state_d = S_LONG;
        default: state_d = state_q;
      endcase
    end
  end

  // Buffer strobes, counter updates and error tracking.
  always_comb begin
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    pair_en    = 1'b0;
    wr_addr    = wr_cnt_q[ADDR_W-1:0];
    rd_addr    = rd_cnt_q[ADDR_W-1:0];
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    sof_pend_d = sof_pend_q;
    if (acc_sof) begin
      wr_en      = 1'b1;
      wr_addr    = '0;
      wr_cnt_d   = ONE;
      rd_cnt_d   = '0;
      err_d      = 1'b0;
      sof_pend_d = 1'b1;
      if (eol_i) len_d = ONE;
    end else if (valid_i) begin
      case (state_q)
        S_LONG: begin
          if (wr_cnt_q < LMAX) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + ONE;
          end else begin
            err_d = 1'b1;
          end
          if (eol_i) begin
            len_d    = (wr_cnt_q < LMAX) ? (wr_cnt_q + ONE) : LMAX;
            rd_cnt_d = '0;
          end
        end
        S_SHORT: begin
          if (rd_cnt_q < len_q) begin
            rd_en      = 1'b1;
            pair_en    = 1'b1;
            rd_cnt_d   = rd_cnt_q + ONE;
            sof_pend_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          if (eol_i) begin
            if ((rd_cnt_q + ONE) != len_q) err_d = 1'b1;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffer. Writes happen only in LONG and reads only in SHORT, so they never collide.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= pix_i;
    if (rd_en) rd_dat_q <= mem[rd_addr];
  end

  // Stage 1: hold the short pixel and its flags alongside the RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_pix_q <= '0;
      s1_sof_q <= 1'b0;
      s1_eol_q <= 1'b0;
    end else begin
      s1_vld_q <= pair_en;
      if (pair_en) begin
        s1_pix_q <= pix_i;
        s1_sof_q <= sof_pend_q;
        s1_eol_q <= eol_i;
      end
    end
  end

  // Stage 2: output register. The data outputs keep their value between pairs.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      eol_o   <= 1'b0;
      data_o0 <= '0;
      data_o1 <= '0;
    end else begin
      valid_o <= s1_vld_q;
      sof_o   <= s1_vld_q & s1_sof_q;
      eol_o   <= s1_vld_q & s1_eol_q;
      if (s1_vld_q) begin
        data_o0 <= rd_dat_q;
        data_o1 <= s1_pix_q;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_hdr_line_pairer.sv
module tb_hdr_line_pairer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pix_i;
  logic       valid_i, sof_i, eol_i;
  logic [7:0] data_o0, data_o1;
  logic       valid_o, sof_o, eol_o, err_o;

  int checks = 0;
  int failures = 0;

  hdr_line_pairer #(.DATA_WIDTH(8), .LINE_MAX(1024), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .pix_i(pix_i), .valid_i(valid_i), .sof_i(sof_i), .eol_i(eol_i),
    .data_o0(data_o0), .data_o1(data_o1), .valid_o(valid_o), .sof_o(sof_o), .eol_o(eol_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix; logic v; logic s; logic e;
    logic ev; logic [7:0] e0; logic [7:0] e1; logic es; logic ee; logic er;
  } vec_t;

  typedef struct { logic [7:0] d0; logic [7:0] d1; logic s; logic e; } pair_t;
  pair_t pq[$];

  // Collect every emitted pair (outputs are stable across the negedge).
  always @(negedge clk) begin
    if (valid_o) pq.push_back('{d0: data_o0, d1: data_o1, s: sof_o, e: eol_o});
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] p, input logic v, input logic s, input logic e);
    pix_i = p; valid_i = v; sof_i = s; eol_i = e;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_pair(input string nm, input int idx, input logic [7:0] d0, input logic [7:0] d1,
                          input logic s, input logic e);
    if (idx >= pq.size()) begin
      checks++; failures++;
      $display("FAIL %s[%0d] missing pair: got_count=%0d", nm, idx, pq.size());
    end else begin
      chk($sformatf("%s[%0d].d0", nm, idx), {24'd0, pq[idx].d0}, {24'd0, d0});
      chk($sformatf("%s[%0d].d1", nm, idx), {24'd0, pq[idx].d1}, {24'd0, d1});
      chk($sformatf("%s[%0d].sof", nm, idx), {31'd0, pq[idx].s}, {31'd0, s});
      chk($sformatf("%s[%0d].eol", nm, idx), {31'd0, pq[idx].e}, {31'd0, e});
    end
  endtask

  function automatic vec_t mk(input logic [7:0] p, input logic v, input logic s, input logic e,
                              input logic ev, input logic [7:0] e0, input logic [7:0] e1,
                              input logic es, input logic ee, input logic er);
    vec_t r;
    r.pix = p; r.v = v; r.s = s; r.e = e;
    r.ev = ev; r.e0 = e0; r.e1 = e1; r.es = es; r.ee = ee; r.er = er;
    return r;
  endfunction

  vec_t vecs[24];

  initial begin
    // Each row gives the inputs for one cycle and the outputs expected right after that cycle's edge.
    // Rows 0-9: back-to-back 4/4 frame. Rows 10-23: the same frame with alternating valid_i gaps.
    vecs[0]  = mk(8'd10, 1, 1, 0,  0, 8'd0,  8'd0, 0, 0, 0);
    vecs[1]  = mk(8'd20, 1, 0, 0,  0, 8'd0,  8'd0, 0, 0, 0);
    vecs[2]  = mk(8'd30, 1, 0, 0,  0, 8'd0,  8'd0, 0, 0, 0);
    vecs[3]  = mk(8'd40, 1, 0, 1,  0, 8'd0,  8'd0, 0, 0, 0);
    vecs[4]  = mk(8'd1,  1, 0, 0,  0, 8'd0,  8'd0, 0, 0, 0);
    vecs[5]  = mk(8'd2,  1, 0, 0,  1, 8'd10, 8'd1, 1, 0, 0);
    vecs[6]  = mk(8'd3,  1, 0, 0,  1, 8'd20, 8'd2, 0, 0, 0);
    vecs[7]  = mk(8'd4,  1, 0, 1,  1, 8'd30, 8'd3, 0, 0, 0);
    vecs[8]  = mk(8'd0,  0, 0, 0,  1, 8'd40, 8'd4, 0, 1, 0);
    vecs[9]  = mk(8'd0,  0, 0, 0,  0, 8'd40, 8'd4, 0, 0, 0);
    vecs[10] = mk(8'd10, 1, 1, 0,  0, 8'd40, 8'd4, 0, 0, 0);
    vecs[11] = mk(8'd0,  0, 0, 0,  0, 8'd40, 8'd4, 0, 0, 0);
    vecs[12] = mk(8'd20, 1, 0, 0,  0, 8'd40, 8'd4, 0, 0, 0);
    vecs[13] = mk(8'd30, 1, 0, 0,  0, 8'd40, 8'd4, 0, 0, 0);
    vecs[14] = mk(8'd40, 1, 0, 1,  0, 8'd40, 8'd4, 0, 0, 0);
    vecs[15] = mk(8'd1,  1, 0, 0,  0, 8'd40, 8'd4, 0, 0, 0);
    vecs[16] = mk(8'd0,  0, 0, 0,  1, 8'd10, 8'd1, 1, 0, 0);
    vecs[17] = mk(8'd2,  1, 0, 0,  0, 8'd10, 8'd1, 0, 0, 0);
    vecs[18] = mk(8'd0,  0, 0, 0,  1, 8'd20, 8'd2, 0, 0, 0);
    vecs[19] = mk(8'd3,  1, 0, 0,  0, 8'd20, 8'd2, 0, 0, 0);
    vecs[20] = mk(8'd0,  0, 0, 0,  1, 8'd30, 8'd3, 0, 0, 0);
    vecs[21] = mk(8'd4,  1, 0, 1,  0, 8'd30, 8'd3, 0, 0, 0);
    vecs[22] = mk(8'd0,  0, 0, 0,  1, 8'd40, 8'd4, 0, 1, 0);
    vecs[23] = mk(8'd0,  0, 0, 0,  0, 8'd40, 8'd4, 0, 0, 0);

    reset = 1'b1; pix_i = 8'd0; valid_i = 1'b0; sof_i = 1'b0; eol_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset.sof_o",   {31'd0, sof_o},   32'd0);
    chk("reset.eol_o",   {31'd0, eol_o},   32'd0);
    chk("reset.err_o",   {31'd0, err_o},   32'd0);
    chk("reset.data_o0", {24'd0, data_o0}, 32'd0);
    chk("reset.data_o1", {24'd0, data_o1}, 32'd0);
    reset = 1'b0;

    // Table-driven frames.
    for (int i = 0; i < 24; i++) begin
      cyc(vecs[i].pix, vecs[i].v, vecs[i].s, vecs[i].e);
      chk($sformatf("vec[%0d].valid_o", i), {31'd0, valid_o}, {31'd0, vecs[i].ev});
      chk($sformatf("vec[%0d].data_o0", i), {24'd0, data_o0}, {24'd0, vecs[i].e0});
      chk($sformatf("vec[%0d].data_o1", i), {24'd0, data_o1}, {24'd0, vecs[i].e1});
      chk($sformatf("vec[%0d].sof_o", i),   {31'd0, sof_o},   {31'd0, vecs[i].es});
      chk($sformatf("vec[%0d].eol_o", i),   {31'd0, eol_o},   {31'd0, vecs[i].ee});
      chk($sformatf("vec[%0d].err_o", i),   {31'd0, err_o},   {31'd0, vecs[i].er});
    end

    // Short line one pixel too long: the 5th short pixel is dropped and the error sticks.
    pq.delete();
    cyc(8'd10, 1, 1, 0); cyc(8'd20, 1, 0, 0); cyc(8'd30, 1, 0, 0); cyc(8'd40, 1, 0, 1);
    for (int i = 1; i <= 5; i++) cyc(8'(i), 1, 0, i == 5);
    idle(3);
    chk("long5.count", pq.size(), 32'd4);
    chk_pair("long5", 0, 8'd10, 8'd1, 1, 0);
    chk_pair("long5", 1, 8'd20, 8'd2, 0, 0);
    chk_pair("long5", 2, 8'd30, 8'd3, 0, 0);
    chk_pair("long5", 3, 8'd40, 8'd4, 0, 0);
    chk("long5.err_o", {31'd0, err_o}, 32'd1);
    idle(5);
    chk("long5.err_sticky", {31'd0, err_o}, 32'd1);

    // Short line one pixel short, then a correct row while the error stays set.
    pq.delete();
    cyc(8'd50, 1, 1, 0);
    chk("short3.err_cleared_by_sof", {31'd0, err_o}, 32'd0);
    cyc(8'd60, 1, 0, 0); cyc(8'd70, 1, 0, 0); cyc(8'd80, 1, 0, 1);
    cyc(8'd5, 1, 0, 0); cyc(8'd6, 1, 0, 0); cyc(8'd7, 1, 0, 1);
    idle(3);
    chk("short3.err_o", {31'd0, err_o}, 32'd1);
    cyc(8'd90, 1, 0, 0); cyc(8'd100, 1, 0, 0); cyc(8'd110, 1, 0, 0); cyc(8'd120, 1, 0, 1);
    cyc(8'd8, 1, 0, 0); cyc(8'd9, 1, 0, 0); cyc(8'd10, 1, 0, 0); cyc(8'd11, 1, 0, 1);
    idle(3);
    chk("short3.count", pq.size(), 32'd7);
    chk_pair("short3", 0, 8'd50, 8'd5, 1, 0);
    chk_pair("short3", 1, 8'd60, 8'd6, 0, 0);
    chk_pair("short3", 2, 8'd70, 8'd7, 0, 1);
    chk_pair("short3", 3, 8'd90, 8'd8, 0, 0);
    chk_pair("short3", 4, 8'd100, 8'd9, 0, 0);
    chk_pair("short3", 5, 8'd110, 8'd10, 0, 0);
    chk_pair("short3", 6, 8'd120, 8'd11, 0, 1);

    // Long line of LINE_MAX+2 pixels: the last two are dropped and the stored length saturates at LINE_MAX.
    pq.delete();
    for (int i = 0; i < 1026; i++) cyc(8'(i), 1, i == 0, i == 1025);
    chk("ovf.err_after_long", {31'd0, err_o}, 32'd1);
    for (int i = 0; i < 1025; i++) cyc(8'(i + 3), 1, 0, i == 1024);
    idle(3);
    chk("ovf.count", pq.size(), 32'd1024);
    chk_pair("ovf", 0,    8'd0,   8'd3,  1, 0);
    chk_pair("ovf", 600,  8'd88,  8'd91, 0, 0);
    chk_pair("ovf", 1023, 8'd255, 8'd2,  0, 0);
    chk("ovf.err_o", {31'd0, err_o}, 32'd1);

    // sof arriving mid-SHORT: resync with the new long line at address 0 and clear the error.
    pq.delete();
    cyc(8'd1, 1, 0, 0); cyc(8'd2, 1, 0, 0); cyc(8'd3, 1, 0, 0); cyc(8'd4, 1, 0, 1);
    cyc(8'd11, 1, 0, 0); cyc(8'd12, 1, 0, 0);
    chk("resync.err_before", {31'd0, err_o}, 32'd1);
    cyc(8'd200, 1, 1, 0);
    chk("resync.err_cleared", {31'd0, err_o}, 32'd0);
    cyc(8'd201, 1, 0, 0); cyc(8'd202, 1, 0, 1);
    cyc(8'd7, 1, 0, 0); cyc(8'd8, 1, 0, 0); cyc(8'd9, 1, 0, 1);
    idle(3);
    chk("resync.count", pq.size(), 32'd5);
    chk_pair("resync", 0, 8'd1,   8'd11, 0, 0);
    chk_pair("resync", 1, 8'd2,   8'd12, 0, 0);
    chk_pair("resync", 2, 8'd200, 8'd7,  1, 0);
    chk_pair("resync", 3, 8'd201, 8'd8,  0, 0);
    chk_pair("resync", 4, 8'd202, 8'd9,  0, 1);
    chk("resync.err_end", {31'd0, err_o}, 32'd0);

    // Reset in the middle of a short line: the pipeline empties and pixels are ignored until sof.
    cyc(8'd10, 1, 1, 0); cyc(8'd20, 1, 0, 0); cyc(8'd30, 1, 0, 0); cyc(8'd40, 1, 0, 1);
    cyc(8'd1, 1, 0, 0); cyc(8'd2, 1, 0, 0);
    reset = 1'b1;
    cyc(8'd3, 1, 0, 0);
    chk("rst_mid.valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_mid.data_o0", {24'd0, data_o0}, 32'd0);
    chk("rst_mid.sof_o",   {31'd0, sof_o},   32'd0);
    reset = 1'b0;
    pq.delete();
    cyc(8'd5, 1, 0, 0); cyc(8'd6, 1, 0, 1); cyc(8'd7, 1, 0, 0); cyc(8'd8, 1, 0, 1);
    idle(3);
    chk("rst_mid.ignored_count", pq.size(), 32'd0);
    chk("rst_mid.err_o", {31'd0, err_o}, 32'd0);
    cyc(8'd33, 1, 1, 0); cyc(8'd44, 1, 0, 1);
    cyc(8'd3, 1, 0, 0); cyc(8'd4, 1, 0, 1);
    idle(3);
    chk("rst_mid.count", pq.size(), 32'd2);
    chk_pair("rst_mid", 0, 8'd33, 8'd3, 1, 0);
    chk_pair("rst_mid", 1, 8'd44, 8'd4, 0, 1);
    chk("rst_mid.err_end", {31'd0, err_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
